// File: rtl/flags_condition_unit_pkg.sv
// Shared definitions for the JAM-1 flags/condition unit: flag bit positions,
// condition-code encodings and carry-source select encodings.
package flags_pkg;

  localparam int NUM_FLAGS = 4;

  localparam int FLAG_C = 0;
  localparam int FLAG_Z = 1;
  localparam int FLAG_S = 2;
  localparam int FLAG_O = 3;

  typedef enum logic [3:0] {
    COND_O      = 4'd0,
    COND_NO     = 4'd1,
    COND_S      = 4'd2,
    COND_NS     = 4'd3,
    COND_Z      = 4'd4,
    COND_NZ     = 4'd5,
    COND_C      = 4'd6,
    COND_NC     = 4'd7,
    COND_CZ     = 4'd8,
    COND_NCZ    = 4'd9,
    COND_LT     = 4'd10,
    COND_GE     = 4'd11,
    COND_LE     = 4'd12,
    COND_GT     = 4'd13,
    COND_ALWAYS = 4'd14,
    COND_NEVER  = 4'd15
  } cond_e;

  typedef enum logic [1:0] {
    CSEL_ARITH = 2'b00,
    CSEL_LOGIC = 2'b01,
    CSEL_ZERO  = 2'b10,
    CSEL_ONE   = 2'b11
  } carry_sel_e;

  function automatic logic [NUM_FLAGS-1:0] pack_flags(input logic c, input logic z,
                                                       input logic s, input logic o);
    logic [NUM_FLAGS-1:0] f;
    f         = '0;
    f[FLAG_C] = c;
    f[FLAG_Z] = z;
    f[FLAG_S] = s;
    f[FLAG_O] = o;
    return f;
  endfunction

endpackage

// File: rtl/flags_condition_unit_if.sv
// ALU-to-flags-unit bundle: ALU flag outputs, bus load/save/restore controls,
// condition request and the registered results.
interface flags_condition_unit_if #(
  parameter int FLAGS_W = 8
);
  logic               ArithCarryFlag;
  logic               LogicCarryFlag;
  logic               ZeroFlag;
  logic               SignFlag;
  logic               OverflowFlag;
  logic               CarrySelectADelayed;
  logic               CarrySelectBDelayed;
  logic               FlagsWrite;
  logic               FlagsLoad;
  logic [FLAGS_W-1:0] FlagsDataIn;
  logic               FlagsSave;
  logic               FlagsRestore;
  logic               CondValid;
  logic [3:0]         CondCode;
  logic [FLAGS_W-1:0] FlagsDataOut;
  logic               CondTaken;
  logic               CondTakenValid;
  logic               ShadowValid;

  modport master (
    output ArithCarryFlag, LogicCarryFlag, ZeroFlag, SignFlag, OverflowFlag,
           CarrySelectADelayed, CarrySelectBDelayed, FlagsWrite, FlagsLoad,
           FlagsDataIn, FlagsSave, FlagsRestore, CondValid, CondCode,
    input  FlagsDataOut, CondTaken, CondTakenValid, ShadowValid
  );

  modport slave (
    input  ArithCarryFlag, LogicCarryFlag, ZeroFlag, SignFlag, OverflowFlag,
           CarrySelectADelayed, CarrySelectBDelayed, FlagsWrite, FlagsLoad,
           FlagsDataIn, FlagsSave, FlagsRestore, CondValid, CondCode,
    output FlagsDataOut, CondTaken, CondTakenValid, ShadowValid
  );

endinterface

// File: rtl/flags_condition_unit_cond_eval.sv
// Combinational branch-condition evaluator over the four architectural flags;
// kept standalone so predication logic can reuse it.
module cond_eval
  import flags_pkg::*;
(
  input  logic [NUM_FLAGS-1:0] i_flags,
  input  logic [3:0]           i_cond_code,
  output logic                 o_taken
);

  logic w_c, w_z, w_s, w_o, w_lt;

  assign w_c  = i_flags[FLAG_C];
  assign w_z  = i_flags[FLAG_Z];
  assign w_s  = i_flags[FLAG_S];
  assign w_o  = i_flags[FLAG_O];
  assign w_lt = w_s ^ w_o;

  always_comb begin
    o_taken = 1'b0;
    case (cond_e'(i_cond_code))
      COND_O:      o_taken = w_o;
      COND_NO:     o_taken = ~w_o;
      COND_S:      o_taken = w_s;
      COND_NS:     o_taken = ~w_s;
      COND_Z:      o_taken = w_z;
      COND_NZ:     o_taken = ~w_z;
      COND_C:      o_taken = w_c;
      COND_NC:     o_taken = ~w_c;
      COND_CZ:     o_taken = w_c | w_z;
      COND_NCZ:    o_taken = ~(w_c | w_z);
      COND_LT:     o_taken = w_lt;
      COND_GE:     o_taken = ~w_lt;
      COND_LE:     o_taken = w_lt | w_z;
      COND_GT:     o_taken = ~(w_lt | w_z);
      COND_ALWAYS: o_taken = 1'b1;
      COND_NEVER:  o_taken = 1'b0;
      default:     o_taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/flags_condition_unit.sv
// Architectural flags register with bus load, optional one-deep shadow
// (FLAGS_SHADOW_EN) and registered branch-condition evaluation on bypassed flags.
module flags_condition_unit
  import flags_pkg::*;
#(
  parameter int                 FLAGS_W     = 8,
  parameter logic [FLAGS_W-1:0] RESET_FLAGS = 8'h00
) (
  input  logic                  clk,
  input  logic                  rst_n,
  flags_condition_unit_if.slave bus
);

  logic [NUM_FLAGS-1:0] r_flags;
  logic [NUM_FLAGS-1:0] w_flags_next;
  logic [NUM_FLAGS-1:0] w_alu_flags;
  logic [NUM_FLAGS-1:0] w_load_flags;
  logic                 w_carry;
  logic                 w_cond_taken;
  logic                 r_cond_taken;
  logic                 r_cond_valid;

  always_comb begin
    w_carry = 1'b0;
    case (carry_sel_e'({bus.CarrySelectBDelayed, bus.CarrySelectADelayed}))
      CSEL_ARITH: w_carry = bus.ArithCarryFlag;
      CSEL_LOGIC: w_carry = bus.LogicCarryFlag;
      CSEL_ZERO:  w_carry = 1'b0;
      CSEL_ONE:   w_carry = 1'b1;
      default:    w_carry = 1'b0;
    endcase
  end

  assign w_alu_flags  = pack_flags(w_carry, bus.ZeroFlag, bus.SignFlag, bus.OverflowFlag);
  assign w_load_flags = bus.FlagsDataIn[NUM_FLAGS-1:0];

  // Upper data-bus bits carry no state and are discarded on load.
  logic w_unused_din;
  assign w_unused_din = ^bus.FlagsDataIn[FLAGS_W-1:NUM_FLAGS];

`ifdef FLAGS_SHADOW_EN
  logic [NUM_FLAGS-1:0] r_shadow;
  logic                 r_shadow_valid;
  logic                 w_restore_hit;

  assign w_restore_hit = bus.FlagsRestore & r_shadow_valid;

  // Save samples the pre-update flags, so Save+Restore swaps the two copies.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow       <= '0;
      r_shadow_valid <= 1'b0;
    end else if (bus.FlagsSave) begin
      r_shadow       <= r_flags;
      r_shadow_valid <= 1'b1;
    end else if (w_restore_hit) begin
      r_shadow_valid <= 1'b0;
    end
  end

  always_comb begin
    w_flags_next = r_flags;
    if (w_restore_hit) begin
      w_flags_next = r_shadow;
    end else if (bus.FlagsLoad) begin
      w_flags_next = w_load_flags;
    end else if (bus.FlagsWrite) begin
      w_flags_next = w_alu_flags;
    end
  end

  assign bus.ShadowValid = r_shadow_valid;
`else
  logic w_unused_shadow_ctl;
  assign w_unused_shadow_ctl = bus.FlagsSave ^ bus.FlagsRestore;

  always_comb begin
    w_flags_next = r_flags;
    if (bus.FlagsLoad) begin
      w_flags_next = w_load_flags;
    end else if (bus.FlagsWrite) begin
      w_flags_next = w_alu_flags;
    end
  end

  assign bus.ShadowValid = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flags <= RESET_FLAGS[NUM_FLAGS-1:0];
    end else begin
      r_flags <= w_flags_next;
    end
  end

  // w_flags_next equals r_flags when nothing updates, so it is the bypass value.
  cond_eval u_cond_eval (
    .i_flags     (w_flags_next),
    .i_cond_code (bus.CondCode),
    .o_taken     (w_cond_taken)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cond_taken <= 1'b0;
      r_cond_valid <= 1'b0;
    end else begin
      r_cond_valid <= bus.CondValid;
      if (bus.CondValid) begin
        r_cond_taken <= w_cond_taken;
      end
    end
  end

  assign bus.FlagsDataOut   = {{(FLAGS_W-NUM_FLAGS){1'b0}}, r_flags};
  assign bus.CondTaken      = r_cond_taken;
  assign bus.CondTakenValid = r_cond_valid;

endmodule

// File: tb/tb_flags_condition_unit.sv
// Scoreboard bench for flags_condition_unit; shadow vectors follow FLAGS_SHADOW_EN.
module tb_flags_condition_unit;
  import flags_pkg::*;

  localparam int FLAGS_W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  flags_condition_unit_if #(.FLAGS_W(FLAGS_W)) bus ();

  flags_condition_unit #(
    .FLAGS_W     (FLAGS_W),
    .RESET_FLAGS (8'h00)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct {
    int         id;
    logic [7:0] flags;
    logic       sv;
    logic       ctv;
    logic       ct;
  } exp_t;

  exp_t sb_q[$];
  int   assert_cnt = 0;
  int   fail_cnt   = 0;

  task automatic chk(input int id, input string nm, input logic [7:0] act, input logic [7:0] exp);
    assert_cnt++;
    if (act !== exp) begin
      fail_cnt++;
      $display("FAIL step %0d %s: got %02h expected %02h", id, nm, act, exp);
    end
  endtask

  // Monitor: one expectation per driven step, checked 1 ns after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        chk(e.id, "flags", bus.FlagsDataOut, e.flags);
        chk(e.id, "shadow_valid", {7'd0, bus.ShadowValid}, {7'd0, e.sv});
        chk(e.id, "cond_valid", {7'd0, bus.CondTakenValid}, {7'd0, e.ctv});
        if (e.ctv) chk(e.id, "cond_taken", {7'd0, bus.CondTaken}, {7'd0, e.ct});
        $display("step %0d: flags=%02h sv=%0b ctv=%0b ct=%0b", e.id, bus.FlagsDataOut,
                 bus.ShadowValid, bus.CondTakenValid, bus.CondTaken);
      end
    end
  end

  task automatic idle_inputs();
    bus.ArithCarryFlag = 0; bus.LogicCarryFlag = 0; bus.ZeroFlag = 0;
    bus.SignFlag = 0; bus.OverflowFlag = 0;
    bus.CarrySelectADelayed = 0; bus.CarrySelectBDelayed = 0;
    bus.FlagsWrite = 0; bus.FlagsLoad = 0; bus.FlagsDataIn = 8'h00;
    bus.FlagsSave = 0; bus.FlagsRestore = 0; bus.CondValid = 0; bus.CondCode = 4'd0;
  endtask

  // One clock of stimulus plus its hand-computed expected result.
  task automatic step(input int id, input logic wr, input logic ld, input logic [7:0] din,
                      input logic sav, input logic rs, input logic [1:0] sel,
                      input logic ac, input logic lc, input logic z, input logic s,
                      input logic o, input logic cv, input logic [3:0] cc,
                      input logic [7:0] ef, input logic esv, input logic ect);
    exp_t e;
    @(posedge clk);
    #2;
    bus.FlagsWrite = wr; bus.FlagsLoad = ld; bus.FlagsDataIn = din;
    bus.FlagsSave = sav; bus.FlagsRestore = rs;
    bus.CarrySelectBDelayed = sel[1]; bus.CarrySelectADelayed = sel[0];
    bus.ArithCarryFlag = ac; bus.LogicCarryFlag = lc;
    bus.ZeroFlag = z; bus.SignFlag = s; bus.OverflowFlag = o;
    bus.CondValid = cv; bus.CondCode = cc;
    e.id = id; e.flags = ef; e.sv = esv; e.ctv = cv; e.ct = ect;
    sb_q.push_back(e);
  endtask

  initial begin
    idle_inputs();
    #3;
    chk(0, "reset_flags", bus.FlagsDataOut, 8'h00);
    chk(0, "reset_cond_valid", {7'd0, bus.CondTakenValid}, 8'h00);
    chk(0, "reset_shadow_valid", {7'd0, bus.ShadowValid}, 8'h00);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    //   id wr ld din   sv rs sel   ac lc z  s  o  cv cc     ef     esv ect
    step( 1, 1, 0, 8'h00, 0, 0, 2'b01, 0, 1, 1, 0, 0, 0, 4'd0,  8'h03, 0, 0);
    step( 2, 1, 0, 8'h00, 0, 0, 2'b11, 0, 0, 0, 0, 0, 0, 4'd0,  8'h01, 0, 0);
    step( 3, 1, 0, 8'h00, 0, 0, 2'b10, 1, 1, 1, 0, 0, 1, 4'd4,  8'h02, 0, 1);
    step( 4, 1, 0, 8'h00, 0, 0, 2'b00, 1, 0, 1, 0, 0, 1, 4'd5,  8'h03, 0, 0);
    step( 5, 1, 0, 8'h00, 0, 0, 2'b00, 0, 0, 0, 0, 0, 1, 4'd9,  8'h00, 0, 1);
    step( 6, 0, 1, 8'hF4, 0, 0, 2'b00, 0, 0, 0, 0, 0, 1, 4'd10, 8'h04, 0, 1);
    step( 7, 0, 0, 8'h00, 0, 0, 2'b00, 0, 0, 0, 0, 0, 1, 4'd11, 8'h04, 0, 0);
    step( 8, 0, 0, 8'h00, 0, 0, 2'b00, 0, 0, 0, 0, 0, 1, 4'd12, 8'h04, 0, 1);
    step( 9, 0, 0, 8'h00, 0, 0, 2'b00, 0, 0, 0, 0, 0, 1, 4'd13, 8'h04, 0, 0);
    step(10, 0, 0, 8'h00, 0, 0, 2'b00, 0, 0, 0, 0, 0, 1, 4'd15, 8'h04, 0, 0);
    step(11, 0, 0, 8'h00, 0, 0, 2'b00, 0, 0, 0, 0, 0, 1, 4'd14, 8'h04, 0, 1);
    step(12, 0, 0, 8'h00, 0, 0, 2'b00, 0, 0, 0, 0, 0, 1, 4'd3,  8'h04, 0, 0);
    step(13, 0, 0, 8'h00, 0, 0, 2'b00, 0, 0, 0, 0, 0, 1, 4'd2,  8'h04, 0, 1);
    step(14, 0, 0, 8'h00, 0, 0, 2'b00, 0, 0, 0, 0, 0, 1, 4'd1,  8'h04, 0, 1);
    step(15, 1, 1, 8'h08, 0, 0, 2'b11, 0, 0, 1, 0, 0, 1, 4'd0,  8'h08, 0, 1);
    step(16, 0, 0, 8'h00, 0, 0, 2'b00, 0, 0, 0, 0, 0, 1, 4'd8,  8'h08, 0, 0);

    // Asynchronous reset mid-cycle while CondTakenValid is high.
    @(posedge clk);
    #2;
    idle_inputs();
    #1;
    rst_n = 1'b0;
    #1;
    chk(90, "midreset_flags", bus.FlagsDataOut, 8'h00);
    chk(90, "midreset_cond_valid", {7'd0, bus.CondTakenValid}, 8'h00);
    chk(90, "midreset_cond_taken", {7'd0, bus.CondTaken}, 8'h00);
    chk(90, "midreset_shadow_valid", {7'd0, bus.ShadowValid}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    step(17, 0, 0, 8'h00, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 4'd0,  8'h00, 0, 0);
`ifdef FLAGS_SHADOW_EN
    step(20, 0, 1, 8'h01, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 4'd0,  8'h01, 0, 0);
    step(21, 0, 0, 8'h00, 1, 0, 2'b00, 0, 0, 0, 0, 0, 0, 4'd0,  8'h01, 1, 0);
    step(22, 0, 1, 8'h0A, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 4'd0,  8'h0A, 1, 0);
    step(23, 0, 0, 8'h00, 1, 1, 2'b00, 0, 0, 0, 0, 0, 0, 4'd0,  8'h01, 1, 0);
    step(24, 0, 0, 8'h00, 0, 1, 2'b00, 0, 0, 0, 0, 0, 0, 4'd0,  8'h0A, 0, 0);
    step(25, 0, 1, 8'h08, 0, 1, 2'b00, 0, 0, 0, 0, 0, 0, 4'd0,  8'h08, 0, 0);
    step(26, 0, 0, 8'h00, 1, 0, 2'b00, 0, 0, 0, 0, 0, 0, 4'd0,  8'h08, 1, 0);
    step(27, 0, 1, 8'h0F, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 4'd0,  8'h0F, 1, 0);
    step(28, 1, 1, 8'h03, 0, 1, 2'b11, 0, 0, 1, 0, 0, 1, 4'd6,  8'h08, 0, 0);
`else
    step(20, 0, 1, 8'h01, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 4'd0,  8'h01, 0, 0);
    step(21, 0, 0, 8'h00, 1, 0, 2'b00, 0, 0, 0, 0, 0, 0, 4'd0,  8'h01, 0, 0);
    step(22, 0, 0, 8'h00, 0, 1, 2'b00, 0, 0, 0, 0, 0, 0, 4'd0,  8'h01, 0, 0);
    step(23, 0, 0, 8'h00, 1, 1, 2'b00, 0, 0, 0, 0, 0, 0, 4'd0,  8'h01, 0, 0);
    step(24, 0, 1, 8'h08, 0, 1, 2'b00, 0, 0, 0, 0, 0, 0, 4'd0,  8'h08, 0, 0);
    step(25, 1, 0, 8'h00, 1, 1, 2'b11, 0, 0, 1, 0, 0, 1, 4'd4,  8'h03, 0, 1);
`endif
    step(29, 0, 0, 8'h00, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 4'd0,
`ifdef FLAGS_SHADOW_EN
         8'h08,
`else
         8'h03,
`endif
         0, 0);

    for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(posedge clk);
    #5;
    assert_cnt++;
    if (sb_q.size() != 0) begin
      fail_cnt++;
      $display("FAIL drain: %0d expectations left, required 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule
